mux_nx1_pipe: RTL and testbench

//  Parametrised N-input select stage with per-transaction field-extract mode.

---
 rtl/mux_nx1_pipe.sv | 153 +++++++++++++++
 tb/tb_mux_nx1_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_pipe.sv
// N-input operand select with per-transaction field extract, registered behind a
// valid/ready handshake with a 2-entry skid buffer. Optional feature: MUX_SEL_ERR_EN.
module mux_nx1_pipe #(
    parameter int WIDTH   = 32,
    parameter int N       = 3,
    parameter int FIELD_W = 3,
    localparam int SEL_W  = (N > 2) ? $clog2(N) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [SEL_W-1:0]   SELECT,
    input  logic [1:0]         MODE,
    input  logic [N*WIDTH-1:0] DATA_IN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [WIDTH-1:0]   DATA_OUT,
`ifdef MUX_SEL_ERR_EN
    output logic               SEL_ERR,
`endif
    output logic [SEL_W-1:0]   OUT_SEL
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e             state_q, state_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   sel_q;
    logic [WIDTH-1:0]   skid_data_q;
    logic [SEL_W-1:0]   skid_sel_q;

    logic [WIDTH-1:0]   word;
    logic [WIDTH-1:0]   ext;
    logic               accept;
    logic               push;
    logic               pop;

    // Out-of-range SELECT leaves word at zero.
    always_comb begin
        word = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(SELECT) == k) begin
                word = DATA_IN[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ext = '0;
        case (MODE)
            2'b00: ext = word;
            2'b01, 2'b10: begin
                // MODE[1] selects sign extension of the low field.
                for (int i = 0; i < WIDTH; i++) begin
                    ext[i] = (i < FIELD_W) ? word[i] : (MODE[1] & word[FIELD_W-1]);
                end
            end
            default: ext = '0;
        endcase
    end

    assign accept = IN_VALID && in_ready_q;
    assign pop    = out_valid_q && OUT_READY;

`ifdef MUX_SEL_ERR_EN
    logic in_range;
    logic sel_err_q;

    assign in_range = int'(SELECT) < N;
    // Out-of-range words complete the handshake but never occupy a buffer entry.
    assign push     = accept && in_range;
    assign SEL_ERR  = sel_err_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_err_q <= 1'b0;
        end else if (accept && !in_range) begin
            sel_err_q <= 1'b1;
        end
    end
`else
    assign push = accept;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (push) state_d = StOne;
            StOne: begin
                if (push && !pop) begin
                    state_d = StTwo;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end
            end
            StTwo:   if (pop) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sel_q       <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != StTwo);
            out_valid_q <= (state_d != StEmpty);
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        data_q <= ext;
                        sel_q  <= SELECT;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        data_q <= ext;
                        sel_q  <= SELECT;
                    end else if (push) begin
                        skid_data_q <= ext;
                        skid_sel_q  <= SELECT;
                    end
                end
                StTwo: begin
                    // Skid word follows the output word; it never overtakes.
                    if (pop) begin
                        data_q <= skid_data_q;
                        sel_q  <= skid_sel_q;
                    end
                end
                default: begin
                    data_q <= '0;
                    sel_q  <= '0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign DATA_OUT  = data_q;
    assign OUT_SEL   = sel_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe (N=3, WIDTH=32, FIELD_W=3); follows MUX_SEL_ERR_EN.
module tb_mux_nx1_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  SELECT;
    logic [1:0]  MODE;
    logic [95:0] DATA_IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] DATA_OUT;
    logic [1:0]  OUT_SEL;
`ifdef MUX_SEL_ERR_EN
    logic        SEL_ERR;
`endif

    int checks = 0;
    int errors = 0;

    mux_nx1_pipe #(.WIDTH(32), .N(3), .FIELD_W(3)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SELECT    (SELECT),
        .MODE      (MODE),
        .DATA_IN   (DATA_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DATA_OUT  (DATA_OUT),
`ifdef MUX_SEL_ERR_EN
        .SEL_ERR   (SEL_ERR),
`endif
        .OUT_SEL   (OUT_SEL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET     = 1'b1;
        IN_VALID  = 1'b1;
        SELECT    = 2'd0;
        MODE      = 2'b00;
        DATA_IN   = {32'h0000_0006, 32'hFFFF_FFFD, 32'h1111_1111};
        OUT_READY = 1'b1;

        // 1: reset holds outputs idle even with IN_VALID high
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
            check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
            check("rst_data_out", DATA_OUT, 32'd0);
            check("rst_out_sel", {30'd0, OUT_SEL}, 32'd0);
        end
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        tick();
        check("idle_out_valid", {31'd0, OUT_VALID}, 32'd0);

        // 2: zero-extend low field of input 1
        IN_VALID = 1'b1;
        SELECT   = 2'd1;
        MODE     = 2'b01;
        tick();
        check("zext_valid", {31'd0, OUT_VALID}, 32'd1);
        check("zext_data", DATA_OUT, 32'h0000_0005);
        check("zext_sel", {30'd0, OUT_SEL}, 32'd1);

        // 3: sign-extend, force zero, pass, sign-extend with positive field
        SELECT = 2'd2;
        MODE   = 2'b10;
        tick();
        check("sext_neg", DATA_OUT, 32'hFFFF_FFFE);
        MODE = 2'b11;
        tick();
        check("force_zero", DATA_OUT, 32'd0);
        check("force_zero_sel", {30'd0, OUT_SEL}, 32'd2);
        SELECT = 2'd0;
        MODE   = 2'b00;
        tick();
        check("pass", DATA_OUT, 32'h1111_1111);
        MODE = 2'b10;
        tick();
        check("sext_pos", DATA_OUT, 32'h0000_0001);
        IN_VALID = 1'b0;
        tick();
        check("drain_valid", {31'd0, OUT_VALID}, 32'd0);
        check("drain_ready", {31'd0, IN_READY}, 32'd1);

        // 4: backpressure fills output + skid; C stalls; drain in order
        DATA_IN   = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        MODE      = 2'b00;
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        SELECT    = 2'd0;
        tick();
        check("bp_a_valid", {31'd0, OUT_VALID}, 32'd1);
        check("bp_a_data", DATA_OUT, 32'hAAAA_0001);
        check("bp_a_ready", {31'd0, IN_READY}, 32'd1);
        SELECT = 2'd1;
        tick();
        check("bp_b_ready", {31'd0, IN_READY}, 32'd0);
        check("bp_hold_data", DATA_OUT, 32'hAAAA_0001);
        SELECT = 2'd2;
        tick();
        check("bp_c_stall_ready", {31'd0, IN_READY}, 32'd0);
        check("bp_c_stall_data", DATA_OUT, 32'hAAAA_0001);
        check("bp_c_stall_sel", {30'd0, OUT_SEL}, 32'd0);
        OUT_READY = 1'b1;
        tick();
        check("drain_b_data", DATA_OUT, 32'hBBBB_0002);
        check("drain_b_sel", {30'd0, OUT_SEL}, 32'd1);
        check("drain_b_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        check("drain_c_data", DATA_OUT, 32'hCCCC_0003);
        check("drain_c_sel", {30'd0, OUT_SEL}, 32'd2);
        check("drain_c_valid", {31'd0, OUT_VALID}, 32'd1);
        IN_VALID = 1'b0;
        tick();
        check("drain_done", {31'd0, OUT_VALID}, 32'd0);

        // 5: out-of-range SELECT
        IN_VALID = 1'b1;
        SELECT   = 2'd3;
        tick();
`ifdef MUX_SEL_ERR_EN
        check("oor_dropped", {31'd0, OUT_VALID}, 32'd0);
        check("oor_sel_err", {31'd0, SEL_ERR}, 32'd1);
        IN_VALID = 1'b0;
        tick();
        check("oor_sel_err_sticky", {31'd0, SEL_ERR}, 32'd1);
`else
        check("oor_valid", {31'd0, OUT_VALID}, 32'd1);
        check("oor_data", DATA_OUT, 32'd0);
        check("oor_sel", {30'd0, OUT_SEL}, 32'd3);
        IN_VALID = 1'b0;
        tick();
        check("oor_drain", {31'd0, OUT_VALID}, 32'd0);
`endif

        // 6: reset with both entries full discards them
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        SELECT    = 2'd0;
        tick();
        SELECT = 2'd1;
        tick();
        check("full_ready", {31'd0, IN_READY}, 32'd0);
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        tick();
        check("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("mid_rst_ready", {31'd0, IN_READY}, 32'd1);
        check("mid_rst_data", DATA_OUT, 32'd0);
`ifdef MUX_SEL_ERR_EN
        check("mid_rst_sel_err", {31'd0, SEL_ERR}, 32'd0);
`endif
        RESET     = 1'b0;
        OUT_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_no_ghost", {31'd0, OUT_VALID}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
